gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
Self-checking response side for two-input gate experiments. On a start request, a small FSM drives every 2-bit input vector into an external gate-under-test (GUT). For each vector it waits a settle interval, samples and synchronises the GUT output, and compares it with a parameterised truth table. It reports per-vector failures, an error count and a single pass flag, replacing manual waveform inspection of stimulus runs.

Parameters:
SETTLE_CYCLES, 4, cycles waited after applying a vector before sampling; legal range 2..15 (covers the 2-flop synchroniser plus gate delay); values below 2 are clamped to 2.
TRUTH, 4'b0001, expected GUT output indexed by {gate_a,gate_b}. Default is NOR; 4'b0111 is NAND.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a full 4-vector check; sampled in IDLE only
gate_x  input  1  GUT output, asynchronous to clk
gate_a  output  1  GUT input A
gate_b  output  1  GUT input B
busy  output  1  high from the cycle after start is accepted until DONE is left
done  output  1  one-cycle pulse when results are valid
pass  output  1  high when err_count==0; valid from done, held until next start
fail_mask  output  4  bit i set when vector {a,b}==i mismatched
err_count  output  3  number of mismatching vectors, 0..4

Behaviour:
- Reset (async, rst_n low): state=IDLE; gate_a=gate_b=0; busy=done=pass=0; fail_mask=0; err_count=0; vector index=0; synchroniser flops=0.
- gate_x passes through a 2-flop synchroniser (x_s). Only x_s is compared.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
  - IDLE: start=1 → APPLY. On the same edge: fail_mask, err_count and pass clear, index=0, busy=1. Otherwise stay in IDLE; gate_a/gate_b hold their last values.
  - APPLY (1 cycle): register {gate_a,gate_b} = vector(index); load settle counter with SETTLE_CYCLES; → SETTLE.
  - SETTLE: decrement the counter each cycle; → SAMPLE in the cycle the counter reaches 1. Total SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): compare x_s with TRUTH[vector(index)].
    - On mismatch: set fail_mask[vector(index)] and increment err_count.
    - If index==3 → DONE; else index+1 → APPLY.
  - DONE (1 cycle): done=1; pass=(err_count==0 after the final update); busy=0 on the exit edge; → IDLE.
- gate_a/gate_b are stable from APPLY through SAMPLE of each vector; they change only in APPLY.
- Per-vector time is SETTLE_CYCLES+2 cycles.
  - If start is sampled high at edge 0, done is high during cycle 4*(SETTLE_CYCLES+2)+1.
  - With the default SETTLE_CYCLES=4, this is cycle 25.
- start while busy: ignored; no restart and no queueing. start held high continuously: a new run begins the cycle after DONE.
- err_count cannot overflow (maximum is 4).
- Reset mid-run: immediate return to IDLE with reset values; no done pulse; partial results are discarded.
- Results (pass, fail_mask, err_count) are held unchanged in IDLE until the next accepted start.

Optional Feature:
GRAY_ORDER_EN
- Defined: vector(index) follows Gray order 00,01,11,10, so only one GUT input toggles per step. This limits glitch-induced mis-sampling on multi-level gate structures.
- Undefined: vector(index)=index, i.e. binary order 00,01,10,11.
- In both cases fail_mask is indexed by the vector value {a,b}, not by the step index. Timing is identical.

Test Plan:
- Behavioural NOR GUT with 3-cycle delay, default parameters, start pulse at cycle 0 → vectors 00,01,10,11 in order; done pulse at cycle 25; pass=1; fail_mask=0000; err_count=0.
- gate_x stuck at 0, TRUTH=NOR → fail_mask=0001, err_count=1, pass=0. gate_x stuck at 1 → fail_mask=1110, err_count=3, pass=0.
- TRUTH=4'b0111 with a NAND GUT → pass=1. Same TRUTH with a NOR GUT → fail_mask=0110, err_count=2.
- Second start at cycle 8 (busy) → ignored; done still at cycle 25 and only once. Then start again → results clear on acceptance and the run repeats.
- rst_n low at cycle 10 for 2 cycles → all outputs return to 0 asynchronously; no done. Subsequent start → normal run, done 25 cycles later.
- GRAY_ORDER_EN defined, NOR GUT stuck at 0 → gate_a/gate_b sequence 00,01,11,10 with only one bit changing per step; fail_mask=0001; done timing unchanged.

Source files
------------

// File: rtl/gate_truth_checker_if.sv
// Bus between the truth checker and its stimulus/observer side.
// Carries the start request, the gate-under-test wires and the result flags.
interface gate_truth_checker_if;
  logic       start;
  logic       gate_x;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [2:0] err_count;

  modport master (
    output start,
    output gate_x,
    input  gate_a,
    input  gate_b,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask,
    input  err_count
  );

  modport slave (
    input  start,
    input  gate_x,
    output gate_a,
    output gate_b,
    output busy,
    output done,
    output pass,
    output fail_mask,
    output err_count
  );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps all 2-bit vectors into a gate under test and checks it against TRUTH.
// GRAY_ORDER_EN selects Gray vector order 00,01,11,10 instead of binary.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  TRUTH         = 4'b0001
) (
  input logic clk,
  input logic rst_n,
  gate_truth_checker_if.slave bus
);

  localparam int unsigned SC =
    (SETTLE_CYCLES < 2)  ? 2  :
    (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
  localparam logic [3:0] SETTLE_L = 4'(SC);

  typedef enum logic [2:0] {
    IDLE, APPLY, SETTLE, SAMPLE, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic [3:0] mask_q, mask_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       s1_q, s2_q;
  logic [1:0] vec;
  logic       miss;

`ifdef GRAY_ORDER_EN
  assign vec = idx_q ^ {1'b0, idx_q[1]};
`else
  assign vec = idx_q;
`endif

  assign miss = (s2_q != TRUTH[vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (cnt_q == 4'd1) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == 2'd3) ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    mask_d = mask_q;
    err_d  = err_q;
    pass_d = pass_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        idx_d  = 2'd0;
        mask_d = 4'd0;
        err_d  = 3'd0;
        pass_d = 1'b0;
      end
      APPLY: begin
        {a_d, b_d} = vec;
        cnt_d      = SETTLE_L;
      end
      SETTLE: cnt_d = cnt_q - 4'd1;
      SAMPLE: begin
        if (miss) begin
          mask_d[vec] = 1'b1;
          err_d       = err_q + 3'd1;
        end
        // pass reflects the count including this final vector
        if (idx_q == 2'd3) pass_d = (err_q == 3'd0) && !miss;
        else               idx_d  = idx_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      cnt_q  <= 4'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      mask_q <= 4'd0;
      err_q  <= 3'd0;
      pass_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      mask_q <= mask_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      s1_q   <= bus.gate_x;
      s2_q   <= s1_q;
    end
  end

  assign bus.gate_a    = a_q;
  assign bus.gate_b    = b_q;
  assign bus.fail_mask = mask_q;
  assign bus.err_count = err_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomised GUT tables against NOR and NAND checkers.
// Expected results come from table XOR truth and vector order arithmetic.
module tb_gate_truth_checker;

  localparam logic [3:0] T_NOR  = 4'b0001;
  localparam logic [3:0] T_NAND = 4'b0111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] tbl;
  logic       n1, n2, d1, d2;
  int         n_chk = 0;
  int         n_fail = 0;
  int         ord [4];

  gate_truth_checker_if ifn ();
  gate_truth_checker_if ifd ();

  always #5 clk = ~clk;

  assign ifn.start  = start;
  assign ifd.start  = start;
  assign ifn.gate_x = n2;
  assign ifd.gate_x = d2;

  // GUT: table lookup with two cycles of delay
  always @(posedge clk) begin
    n1 <= tbl[{ifn.gate_a, ifn.gate_b}];
    n2 <= n1;
    d1 <= tbl[{ifd.gate_a, ifd.gate_b}];
    d2 <= d1;
  end

  gate_truth_checker #(.SETTLE_CYCLES(4), .TRUTH(T_NOR)) u_nor (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifn)
  );

  gate_truth_checker #(.SETTLE_CYCLES(4), .TRUTH(T_NAND)) u_nand (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifd)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic chk_res(input string tag, input logic [3:0] t);
    logic [3:0] en, ed;
    en = t ^ T_NOR;
    ed = t ^ T_NAND;
    chk({tag, "_mask_nor"}, 32'(ifn.fail_mask), 32'(en));
    chk({tag, "_err_nor"}, 32'(ifn.err_count), 32'(popc(en)));
    chk({tag, "_pass_nor"}, 32'(ifn.pass), 32'(en == 4'd0));
    chk({tag, "_mask_nand"}, 32'(ifd.fail_mask), 32'(ed));
    chk({tag, "_err_nand"}, 32'(ifd.err_count), 32'(popc(ed)));
    chk({tag, "_pass_nand"}, 32'(ifd.pass), 32'(ed == 4'd0));
  endtask

  task automatic run(input logic [3:0] t, input bit dbl);
    int ndone = 0;
    int dcyc = 0;
    tbl = t;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_start", 32'(ifn.busy), 32'd1);
    for (int e = 1; e <= 30; e++) begin
      if (dbl && e == 7) start = 1'b1;
      if (dbl && e == 9) start = 1'b0;
      @(posedge clk); #1;
      if (ifn.done) begin
        ndone++;
        dcyc = e + 1;
        chk_res("done", t);
      end
      for (int i = 0; i < 4; i++)
        if (e == 6 * i + 2 || e == 6 * i + 5) begin
          chk("vec_nor", 32'({ifn.gate_a, ifn.gate_b}), 32'(ord[i]));
          chk("vec_nand", 32'({ifd.gate_a, ifd.gate_b}), 32'(ord[i]));
        end
      if (e == 12) chk("busy_mid", 32'(ifn.busy), 32'd1);
    end
    chk("done_count", 32'(ndone), 32'd1);
    chk("done_cycle", 32'(dcyc), 32'd25);
    chk("busy_end", 32'(ifn.busy), 32'd0);
    chk_res("held", t);
  endtask

  initial begin
`ifdef GRAY_ORDER_EN
    ord = '{0, 1, 3, 2};
`else
    ord = '{0, 1, 2, 3};
`endif
    rst_n = 1'b0;
    start = 1'b0;
    tbl   = T_NOR;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(ifn.busy), 32'd0);
    chk("rst_done", 32'(ifn.done), 32'd0);
    chk("rst_pass", 32'(ifn.pass), 32'd0);
    chk("rst_mask", 32'(ifn.fail_mask), 32'd0);
    chk("rst_err", 32'(ifn.err_count), 32'd0);
    chk("rst_ab", 32'({ifn.gate_a, ifn.gate_b}), 32'd0);
    rst_n = 1'b1;

    run(T_NOR, 1'b0);
    run(4'b0000, 1'b0);
    run(4'b1111, 1'b0);
    run(T_NAND, 1'b1);
    for (int k = 0; k < 8; k++)
      run(4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));

    run(4'b1111, 1'b0);
    begin
      int nd = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(ifn.busy), 32'd0);
      chk("arst_mask", 32'(ifn.fail_mask), 32'd0);
      chk("arst_err", 32'(ifn.err_count), 32'd0);
      chk("arst_pass", 32'(ifn.pass), 32'd0);
      chk("arst_ab", 32'({ifn.gate_a, ifn.gate_b}), 32'd0);
      chk("arst_mask_nand", 32'(ifd.fail_mask), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int e = 0; e < 20; e++) begin
        @(posedge clk); #1;
        if (ifn.done) nd++;
      end
      chk("arst_no_done", 32'(nd), 32'd0);
    end
    run(T_NOR, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
